// File: rtl/als_light_tone.sv
// -----------------------------------------------------------------------------
// als_light_tone
//   Takes the 16-bit PmodALS SPI frame and samples it at a fixed strobe rate.
//   It extracts the 8-bit light code and smooths it with a first-order IIR.
//   The smoothed level drives an 8-LED thermometer bar graph and a square-wave
//   buzzer tone whose pitch rises with brightness. A hysteretic mute keeps the
//   buzzer silent in the dark.
//
// Ports
//   clock         in   1   system clock, all registers on the rising edge
//   reset         in   1   synchronous, active-high
//   value         in   16  raw ALS frame, may change on any cycle
//   enable        in   1   0 forces the tone low
//   level         out  8   smoothed light level
//   level_update  out  1   one-cycle pulse when level takes a new value
//   bar           out  8   thermometer, bar[i] = (level >= 32*i + 16)
//   tone          out  1   square wave to the buzzer
// -----------------------------------------------------------------------------
module als_light_tone #(
   parameter int clk_mhz          = 50,
   parameter int sample_hz        = 1000,
   parameter int sample_lsb       = 5,
   parameter int avg_shift        = 3,
   parameter int base_half_cycles = 12500,
   parameter int step_shift       = 8,
   parameter int mute_on          = 64,
   parameter int mute_off         = 48
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic        enable,
   output logic [7:0]  level,
   output logic        level_update,
   output logic [7:0]  bar,
   output logic        tone
);

   localparam int div_n = (clk_mhz * 1000000) / sample_hz;
   localparam int div_w = (div_n > 1) ? $clog2(div_n) : 1;
   localparam logic [div_w-1:0] div_last = div_w'(div_n - 1);
   localparam int acc_w = 8 + avg_shift;
   localparam logic [7:0]  mute_on_c  = 8'(mute_on);
   localparam logic [7:0]  mute_off_c = 8'(mute_off);
   localparam logic [23:0] base_c     = 24'(base_half_cycles);

   typedef enum logic [0:0] {
      MUTED  = 1'b0,
      ACTIVE = 1'b1
   } mute_state_t;

   logic [div_w-1:0] div_r;
   logic             strobe_s;
   logic [7:0]       code_s;
   logic [acc_w-1:0] acc_r;
   logic             primed_r;
   logic [7:0]       level_s;
   logic             level_update_r;
   logic [7:0]       bar_r;
   mute_state_t      state_r;
   mute_state_t      state_next_s;
   logic [23:0]      half_s;
   logic [23:0]      cnt_r;
   logic             tone_r;

   // Thermometer code: LED i lights once the level reaches the middle of its 32-step band.
   function automatic logic [7:0] thermometer(input logic [7:0] lvl);
      logic [7:0] thr;
      thermometer = 8'd0;
      for (int i = 0; i < 8; i++) begin
         thr = 8'(32 * i + 16);
         thermometer[i] = (lvl >= thr);
      end
   endfunction

   assign strobe_s = (div_r == div_last);
   assign code_s   = value[sample_lsb +: 8];
   // The accumulator holds level scaled by 2^avg_shift, so level is its top byte.
   assign level_s  = acc_r[acc_w-1 -: 8];
   assign half_s   = base_c + (24'(8'd255 - level_s) << step_shift);

   // Sample-rate divider, wraps after div_n clocks.
   always_ff @(posedge clock) begin
      if (reset) begin
         div_r <= '0;
      end else if (div_r == div_last) begin
         div_r <= '0;
      end else begin
         div_r <= div_r + div_w'(1);
      end
   end

   // IIR accumulator; the first sample after reset preloads it so level does not ramp up from zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_r    <= '0;
         primed_r <= 1'b0;
      end else if (strobe_s) begin
         if (!primed_r) begin
            acc_r <= acc_w'(code_s) << avg_shift;
         end else begin
            acc_r <= acc_r - (acc_r >> avg_shift) + acc_w'(code_s);
         end
         primed_r <= 1'b1;
      end else begin
         acc_r    <= acc_r;
         primed_r <= primed_r;
      end
   end

   // Update pulse aligned with the new level, and the bar graph one clock behind level.
   always_ff @(posedge clock) begin
      if (reset) begin
         level_update_r <= 1'b0;
         bar_r          <= 8'd0;
      end else begin
         level_update_r <= strobe_s;
         bar_r          <= thermometer(level_s);
      end
   end

   // Mute state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= MUTED;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Mute next-state logic: separate on/off thresholds give hysteresis.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         MUTED: begin
            if (level_s >= mute_on_c) begin
               state_next_s = ACTIVE;
            end else begin
               state_next_s = MUTED;
            end
         end
         ACTIVE: begin
            if (level_s < mute_off_c) begin
               state_next_s = MUTED;
            end else begin
               state_next_s = ACTIVE;
            end
         end
         default: begin
            state_next_s = MUTED;
         end
      endcase
   end

   // Tone generator; half-period is sampled only at reload, so a level change never cuts a half-period short.
   always_ff @(posedge clock) begin
      if (reset) begin
         tone_r <= 1'b0;
         cnt_r  <= 24'd0;
      end else if ((state_r == MUTED) || !enable) begin
         tone_r <= 1'b0;
         cnt_r  <= 24'd0;
      end else if (cnt_r == 24'd0) begin
         tone_r <= ~tone_r;
         cnt_r  <= half_s - 24'd1;
      end else begin
         tone_r <= tone_r;
         cnt_r  <= cnt_r - 24'd1;
      end
   end

   assign level        = level_s;
   assign level_update = level_update_r;
   assign bar          = bar_r;
   assign tone         = tone_r;

endmodule
